// File: rtl/uart_rx_if.sv
// CPU-side holding-register port of the 8N1 receiver: read handshake, received data and status flags.
// The receiver drives the slave modport; the bus logic reading bytes uses the master modport.
interface uart_rx_if;
    logic        read_ack;
    logic [31:0] data;
    logic        data_valid;
    logic        frame_err;
    logic        overrun;
    logic        interrupt;

    modport master (
        output read_ack,
        input  data,
        input  data_valid,
        input  frame_err,
        input  overrun,
        input  interrupt
    );

    modport slave (
        input  read_ack,
        output data,
        output data_valid,
        output frame_err,
        output overrun,
        output interrupt
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchroniser, mid-bit sampling from a baud divider counter,
// and a holding register with sticky framing-error and overrun flags.
module uart_rx #(
    parameter int sys_clk = 50000000,
    parameter int baud    = 9600
) (
    input  logic     clock,
    input  logic     nRst,
    input  logic     RX,
    uart_rx_if.slave bus
);

    localparam int          BIT_CNT   = sys_clk / baud - 1;
    localparam int          HALF      = BIT_CNT / 2;
    localparam logic [31:0] BIT_CNT_C = 32'(BIT_CNT);
    localparam logic [31:0] HALF_C    = 32'(HALF);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic        rx_s1, rx_s2;
    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;

    // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!nRst) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_s1     <= RX;
            rx_s2     <= rx_s1;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = ferr_q;
        ovr_d     = ovr_q;

        // The acknowledge clear comes first so a frame completing in the same cycle wins.
        if (bus.read_ack) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s2) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q != HALF_C) begin
                    cnt_d = cnt_q + 32'd1;
                end else if (!rx_s2) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (cnt_q != BIT_CNT_C) begin
                    cnt_d = cnt_q + 32'd1;
                end else begin
                    shift_d[bit_idx_q] = rx_s2;
                    cnt_d              = '0;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            STOP: begin
                if (cnt_q != BIT_CNT_C) begin
                    cnt_d = cnt_q + 32'd1;
                end else begin
                    // Leaving at the stop-bit midpoint leaves half a bit to catch the next start edge.
                    if (rx_s2) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        if (valid_q && !bus.read_ack) ovr_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.data       = {24'd0, data_q};
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;
    assign bus.interrupt  = valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at sys_clk=16, baud=1 (16 clocks per bit, BIT_CNT=15, HALF=7).
module tb_uart_rx;

    logic clock = 1'b0;
    logic nRst  = 1'b0;
    logic rx    = 1'b1;
    int   errors = 0;
    int   checks = 0;

    uart_rx_if bus ();

    uart_rx #(.sys_clk(16), .baud(1)) dut (
        .clock (clock),
        .nRst  (nRst),
        .RX    (rx),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Drives one 160-clock frame; edge e (1-based) is the e-th rising edge after RX falls.
    // ack_at / rst_at put read_ack high / nRst low for that edge; snap_at captures the outputs after it.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int ack_at,
                               input int rst_at, input int snap_at,
                               output int dv_edge, output logic [35:0] snap);
        logic [9:0] frame;
        frame   = {stop_bit, b, 1'b0};
        dv_edge = -1;
        snap    = '0;
        for (int e = 1; e <= 160; e++) begin
            @(negedge clock);
            rx           = frame[(e - 1) / 16];
            bus.read_ack = (e == ack_at);
            nRst         = (e != rst_at);
            @(posedge clock);
            #1;
            if (dv_edge < 0 && bus.data_valid) dv_edge = e;
            if (e == snap_at)
                snap = {bus.data, bus.data_valid, bus.frame_err, bus.overrun, bus.interrupt};
        end
        bus.read_ack = 1'b0;
        nRst         = 1'b1;
        rx           = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            rx = 1'b1;
        end
    endtask

    task automatic ack_pulse();
        @(negedge clock);
        bus.read_ack = 1'b1;
        @(posedge clock);
        #1;
        bus.read_ack = 1'b0;
    endtask

    task automatic test_reset();
        bus.read_ack = 1'b0;
        nRst = 1'b0;
        rx   = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (bus.data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", bus.data); end
        checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.data_valid); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", bus.frame_err); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", bus.overrun); end
        checks++; if (bus.interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", bus.interrupt); end
        @(negedge clock);
        nRst = 1'b1;
        idle(5);
    endtask

    task automatic test_start_glitch();
        int          dv;
        logic [35:0] s;
        @(negedge clock);
        rx = 1'b0;
        repeat (4) @(negedge clock);
        rx = 1'b1;
        idle(30);
        #1;
        checks++; if (bus.data !== 32'h0) begin errors++; $display("FAIL glitch_data: got %h expected 00000000", bus.data); end
        checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b expected 0", bus.data_valid); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL glitch_ferr: got %b expected 0", bus.frame_err); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL glitch_ovr: got %b expected 0", bus.overrun); end
        drive_frame(8'h3C, 1'b1, 0, 0, 160, dv, s);
        checks++; if (s !== {32'h3C, 4'b1001}) begin errors++; $display("FAIL glitch_next_frame: got %h expected %h", s, {32'h3C, 4'b1001}); end
        ack_pulse();
        idle(5);
    endtask

    task automatic test_single();
        int          dv;
        logic [35:0] s;
        drive_frame(8'hA5, 1'b1, 0, 0, 155, dv, s);
        checks++; if (dv !== 155) begin errors++; $display("FAIL single_latency: got %0d expected 155", dv); end
        checks++; if (s[35:4] !== 32'h000000A5) begin errors++; $display("FAIL single_data: got %h expected 000000A5", s[35:4]); end
        checks++; if (s[3] !== 1'b1 || s[0] !== 1'b1) begin errors++; $display("FAIL single_valid_irq: got %b%b expected 11", s[3], s[0]); end
        ack_pulse();
        checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL single_ack_valid: got %b expected 0", bus.data_valid); end
        checks++; if (bus.interrupt !== 1'b0) begin errors++; $display("FAIL single_ack_irq: got %b expected 0", bus.interrupt); end
        idle(5);
    endtask

    task automatic test_frame_err();
        int          dv;
        logic [35:0] s;
        drive_frame(8'h55, 1'b0, 0, 0, 155, dv, s);
        checks++; if (s !== {32'hA5, 4'b0100}) begin errors++; $display("FAIL ferr_set: got %h expected %h", s, {32'hA5, 4'b0100}); end
        idle(30);
        #1;
        checks++; if (bus.frame_err !== 1'b1 || bus.data_valid !== 1'b0) begin errors++; $display("FAIL ferr_sticky: got fe=%b dv=%b expected fe=1 dv=0", bus.frame_err, bus.data_valid); end
        ack_pulse();
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL ferr_ack_clear: got %b expected 0", bus.frame_err); end
        idle(5);
        drive_frame(8'h55, 1'b0, 155, 0, 155, dv, s);
        checks++; if (s[2] !== 1'b1) begin errors++; $display("FAIL ferr_set_beats_ack: got %b expected 1", s[2]); end
        idle(30);
        ack_pulse();
        idle(5);
    endtask

    task automatic test_back_to_back();
        int          dv;
        logic [35:0] s;
        drive_frame(8'h11, 1'b1, 0, 0, 160, dv, s);
        checks++; if (s !== {32'h11, 4'b1001}) begin errors++; $display("FAIL b2b_first: got %h expected %h", s, {32'h11, 4'b1001}); end
        drive_frame(8'h22, 1'b1, 0, 0, 160, dv, s);
        checks++; if (s !== {32'h22, 4'b1011}) begin errors++; $display("FAIL b2b_overrun: got %h expected %h", s, {32'h22, 4'b1011}); end
        drive_frame(8'h33, 1'b1, 155, 0, 155, dv, s);
        checks++; if (s !== {32'h33, 4'b1001}) begin errors++; $display("FAIL b2b_ack_same_cycle: got %h expected %h", s, {32'h33, 4'b1001}); end
        idle(5);
    endtask

    task automatic test_reset_mid_frame();
        int          dv;
        logic [35:0] s;
        drive_frame(8'hFF, 1'b1, 0, 85, 85, dv, s);
        checks++; if (s !== 36'h0) begin errors++; $display("FAIL midreset_outputs: got %h expected 000000000", s); end
        idle(10);
        drive_frame(8'h0F, 1'b1, 0, 0, 160, dv, s);
        checks++; if (s !== {32'h0F, 4'b1001}) begin errors++; $display("FAIL midreset_next: got %h expected %h", s, {32'h0F, 4'b1001}); end
        ack_pulse();
        idle(5);
    endtask

    task automatic test_extremes();
        int          dv;
        logic [35:0] s;
        logic [7:0]  vals [3];
        vals = '{8'h00, 8'hFF, 8'h80};
        for (int i = 0; i < 3; i++) begin
            drive_frame(vals[i], 1'b1, 0, 0, 160, dv, s);
            checks++;
            if (s !== {24'h0, vals[i], 4'b1001}) begin
                errors++;
                $display("FAIL extreme_%02h: got %h expected %h", vals[i], s, {24'h0, vals[i], 4'b1001});
            end
            ack_pulse();
            idle(5);
        end
    endtask

    initial begin
        bus.read_ack = 1'b0;
        test_reset();
        test_start_glitch();
        test_single();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_extremes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the on-chip UART: an 8N1 serial receiver (8 data bits, LSB first, no parity, 1 stop bit). It accepts the external RX line, synchronises it, samples each bit at its midpoint using a clock-divider counter, and presents each completed byte to the CPU-side bus logic in a holding register. The CPU side sees a level-valid / read-acknowledge handshake, a receive interrupt, and sticky framing-error and overrun flags. It pairs with the existing transmitter and uses the same `sys_clk`-derived baud divider.

## Interface
- `sys_clk`, default 50000000: system clock frequency in Hz.
- `baud`, default 9600: line rate in bit/s.
- Derived constant `BIT_CNT` = sys_clk/baud − 1 (integer division). With the defaults, BIT_CNT = 5207.
- Derived constant `HALF` = BIT_CNT/2 (integer division). With the defaults, HALF = 2603.
- Reset and clock (already decided): one clock; reset is synchronous and active-low.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `nRst`  in  1  synchronous, active-low reset.
- `RX`  in  1  asynchronous serial input; idles high.
- `read_ack`  in  1  single-cycle pulse from the CPU side; consumes the held byte and clears the flags.
- `data`  out  32  received byte in bits [7:0]; bits [31:8] are always 0.
- `data_valid`  out  1  the holding register contains an unread byte.
- `frame_err`  out  1  sticky flag: a stop bit was sampled as 0.
- `overrun`  out  1  sticky flag: a byte was overwritten before it was read.
- `interrupt`  out  1  equal to `data_valid`.

## Operation
- **Synchroniser:** RX passes through two flops, `rx_s1` then `rx_s2`. Both reset to 1. All FSM decisions use `rx_s2` only.
- **Counters:** `cnt` is 32 bits wide; `bit_idx` is 3 bits; the shift register is 8 bits.
- **IDLE**
  - If `rx_s2` is 0: set `cnt` to 0 and go to START.
- **START**
  - If `cnt` ≠ HALF: increment `cnt`.
  - If `cnt` = HALF and `rx_s2` is 0: set `cnt` and `bit_idx` to 0, go to DATA.
  - If `cnt` = HALF and `rx_s2` is 1: treat it as a glitch and go to IDLE. No flag changes.
- **DATA**
  - If `cnt` ≠ BIT_CNT: increment `cnt`.
  - If `cnt` = BIT_CNT: set `shift[bit_idx]` to `rx_s2` and set `cnt` to 0.
    - If `bit_idx` = 7: go to STOP.
    - Otherwise: increment `bit_idx`.
- **STOP**
  - If `cnt` ≠ BIT_CNT: increment `cnt`.
  - If `cnt` = BIT_CNT and `rx_s2` is 1 (good frame): load `data[7:0]` from the shift register and set `data_valid`.
  - If `cnt` = BIT_CNT and `rx_s2` is 0 (bad stop bit): set `frame_err`. `data` and `data_valid` are unchanged.
  - In both cases, go to IDLE. IDLE is re-entered at the stop-bit midpoint, so back-to-back frames are accepted.
- **`read_ack`**
  - Clears `data_valid`, `frame_err` and `overrun`.
  - `read_ack` while `data_valid` is 0 clears the flags only.
- **Simultaneous events**
  - Good frame completes while `data_valid` is 1 and `read_ack` is 0: overwrite `data`, keep `data_valid` at 1, set `overrun`.
  - Good frame completes in the same cycle as `read_ack`: load the new byte, `data_valid` ends at 1, `overrun` stays 0.
  - Bad frame completes in the same cycle as `read_ack`: `frame_err` ends at 1; the set wins over the clear.
- **Reset, including mid-frame:** the FSM goes to IDLE; `cnt`, `bit_idx` and the shift register go to 0; `data`, `data_valid`, `frame_err` and `overrun` go to 0; the synchroniser goes to 1.

## Timing
- Reset values of the outputs: `data` = 0, `data_valid` = 0, `frame_err` = 0, `overrun` = 0, `interrupt` = 0.
- Synchroniser latency is 2 cycles. IDLE reacts on the 3rd rising edge after RX falls.
- Start bit is validated HALF+1 edges after entering START. Each data bit and the stop bit take BIT_CNT+1 edges.
- `data_valid` rises HALF + 4 + 9·(BIT_CNT+1) edges after the first edge that captures RX low.
  - Defaults: 49 479 edges.
  - With sys_clk = 16, baud = 1: 155 edges.
- `data_valid`, `frame_err` and `overrun` all change on the edge after the triggering condition; they are registered.
- `interrupt` is combinational from `data_valid`, so it has zero added latency.
- Tolerance: sampling stays within the bit for a combined clock error of ±4 %.

## Test plan
All scenarios use sys_clk = 16, baud = 1 (BIT_CNT = 15, HALF = 7).
- **Single byte:** send 0xA5 as 8N1, 16 cycles per bit → `data` = 0x000000A5 and `data_valid` = `interrupt` = 1 exactly 155 edges after the capture of the RX falling edge. `read_ack` → `data_valid` = 0 on the next cycle.
- **Start glitch:** RX low for 4 cycles, then high → FSM returns to IDLE, all outputs stay 0. A following 0x3C frame is received correctly.
- **Framing error:** send 0x55 with the stop bit held at 0 → `frame_err` = 1, `data_valid` = 0, `data` unchanged. `read_ack` clears `frame_err`.
- **Overrun and back-to-back:** send 0x11 then 0x22 back-to-back with no ack → `data` = 0x22, `data_valid` = 1, `overrun` = 1. Then pulse `read_ack` on the exact cycle a third byte 0x33 completes → `data` = 0x33, `data_valid` = 1, `overrun` = 0.
- **Reset mid-frame:** pull `nRst` low during bit 4 of 0xFF → on the next edge all outputs are 0 and the FSM is in IDLE. After release, 0x0F is received correctly.
- **Bit order and extremes:** send 0x00, 0xFF and 0x80 (MSB transmitted last) → `data[7:0]` matches each byte and `data[31:8]` = 0.
